// File: rtl/rs_age_issue_queue.sv
// rs_age_issue_queue: age-ordered reservation station with multi-port CDB wakeup and back-pressured issue
module rs_age_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int OP_W    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [TAG_W-1:0]                  alloc_tag,
    input  logic [OP_W-1:0]                   alloc_op,
    input  logic                              alloc_busy1,
    input  logic                              alloc_busy2,
    input  logic [XLEN-1:0]                   alloc_src1,
    input  logic [XLEN-1:0]                   alloc_src2,
    input  logic [NUM_CDB-1:0]                cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag,
    input  logic [NUM_CDB-1:0][XLEN-1:0]      cdb_data,
    output logic                              issue_valid,
    input  logic                              issue_ready,
    output logic [TAG_W-1:0]                  issue_tag,
    output logic [OP_W-1:0]                   issue_op,
    output logic [XLEN-1:0]                   issue_src1,
    output logic [XLEN-1:0]                   issue_src2,
    output logic [$clog2(DEPTH):0]            num_free
);
    localparam int NW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]             valid, busy1, busy2, ready, sel, free_oh;
    logic [DEPTH-1:0][TAG_W-1:0]  tag;
    logic [DEPTH-1:0][OP_W-1:0]   op;
    logic [DEPTH-1:0][XLEN-1:0]   src1, src2;
    logic [DEPTH-1:0][XLEN:0]     wake1, wake2;
    // age[r][c] set means entry c was allocated before entry r
    logic [DEPTH-1:0][DEPTH-1:0]  age;
    logic [XLEN:0]                byp1, byp2;
    logic                         fire_alloc, fire_issue;

    // {hit, data} of the lowest-index CDB port broadcasting tag t
    function automatic logic [XLEN:0] snoop(
        input logic [TAG_W-1:0]               t,
        input logic [NUM_CDB-1:0]             v,
        input logic [NUM_CDB-1:0][TAG_W-1:0]  tg,
        input logic [NUM_CDB-1:0][XLEN-1:0]   d
    );
        snoop = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--)
            if (v[p] && tg[p] == t) snoop = {1'b1, d[p]};
    endfunction

    assign ready       = valid & ~busy1 & ~busy2;
    assign free_oh     = ~valid & (valid + DEPTH'(1));
    assign alloc_ready = num_free != '0;
    assign issue_valid = |ready;
    assign fire_alloc  = alloc_valid && alloc_ready;
    assign fire_issue  = issue_valid && issue_ready;
    assign byp1        = snoop(alloc_src1[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    assign byp2        = snoop(alloc_src2[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);

    // per-entry CDB match on the tag held in each operand
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = snoop(src1[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
            wake2[i] = snoop(src2[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
        end
    end

    // oldest-ready select: a ready entry wins when no other ready entry predates it
    always_comb begin
        sel        = '0;
        issue_tag  = '0;
        issue_op   = '0;
        issue_src1 = '0;
        issue_src2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i] && !(|(ready & age[i]));
            if (sel[i]) begin
                issue_tag  = tag[i];
                issue_op   = op[i];
                issue_src1 = src1[i];
                issue_src2 = src2[i];
            end
        end
    end

    // entry state: wakeup, issue retire and allocation land on the same edge; flush overrides them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            busy1    <= '0;
            busy2    <= '0;
            tag      <= '0;
            op       <= '0;
            src1     <= '0;
            src2     <= '0;
            age      <= '0;
            num_free <= NW'(DEPTH);
        end else if (flush) begin
            valid    <= '0;
            age      <= '0;
            num_free <= NW'(DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && busy1[i] && wake1[i][XLEN]) begin
                    src1[i]  <= wake1[i][XLEN-1:0];
                    busy1[i] <= 1'b0;
                end
                if (valid[i] && busy2[i] && wake2[i][XLEN]) begin
                    src2[i]  <= wake2[i][XLEN-1:0];
                    busy2[i] <= 1'b0;
                end
                if (fire_issue && sel[i]) valid[i] <= 1'b0;
                if (fire_alloc) age[i] <= age[i] & ~free_oh;
                if (fire_alloc && free_oh[i]) begin
                    valid[i] <= 1'b1;
                    tag[i]   <= alloc_tag;
                    op[i]    <= alloc_op;
                    busy1[i] <= alloc_busy1 && !byp1[XLEN];
                    busy2[i] <= alloc_busy2 && !byp2[XLEN];
                    src1[i]  <= (alloc_busy1 && byp1[XLEN]) ? byp1[XLEN-1:0] : alloc_src1;
                    src2[i]  <= (alloc_busy2 && byp2[XLEN]) ? byp2[XLEN-1:0] : alloc_src2;
                    age[i]   <= valid;
                end
            end
            num_free <= num_free + NW'(fire_issue) - NW'(fire_alloc);
        end
    end
endmodule

// File: tb/tb_rs_age_issue_queue.sv
// tb_rs_age_issue_queue: directed scenarios plus randomized run against a sequence-number reference model
module tb_rs_age_issue_queue;
    localparam int D = 8, X = 32, T = 4, N = 2, O = 4;

    logic clk = 0, rst = 1, flush = 0;
    logic alloc_valid = 0, alloc_ready;
    logic [T-1:0] alloc_tag = 0;
    logic [O-1:0] alloc_op = 0;
    logic alloc_busy1 = 0, alloc_busy2 = 0;
    logic [X-1:0] alloc_src1 = 0, alloc_src2 = 0;
    logic [N-1:0] cdb_valid = 0;
    logic [N-1:0][T-1:0] cdb_tag = 0;
    logic [N-1:0][X-1:0] cdb_data = 0;
    logic issue_valid, issue_ready = 0;
    logic [T-1:0] issue_tag;
    logic [O-1:0] issue_op;
    logic [X-1:0] issue_src1, issue_src2;
    logic [3:0] num_free;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    rs_age_issue_queue #(.DEPTH(D), .XLEN(X), .TAG_W(T), .NUM_CDB(N), .OP_W(O)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .alloc_op(alloc_op),
        .alloc_busy1(alloc_busy1), .alloc_busy2(alloc_busy2), .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag), .issue_op(issue_op),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .num_free(num_free)
    );

    // reference model: slots with allocation sequence numbers; oldest ready = smallest sequence
    bit m_v[D], m_b1[D], m_b2[D];
    int m_seq[D];
    int m_next = 0;
    logic [T-1:0] m_tag[D];
    logic [O-1:0] m_op[D];
    logic [X-1:0] m_s1[D], m_s2[D];

    function automatic int m_free();
        int n = D;
        for (int i = 0; i < D; i++) if (m_v[i]) n--;
        return n;
    endfunction

    function automatic int m_pick();
        int best = -1;
        for (int i = 0; i < D; i++)
            if (m_v[i] && !m_b1[i] && !m_b2[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        return best;
    endfunction

    function automatic logic [X:0] m_snoop(input logic [T-1:0] t);
        for (int p = 0; p < N; p++)
            if (cdb_valid[p] && cdb_tag[p] == t) return {1'b1, cdb_data[p]};
        return '0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < D; i++) m_v[i] = 0;
        m_next = 0;
    endtask

    task automatic m_edge();
        int pk, fr;
        bit fa;
        logic [X:0] w;
        pk = m_pick();
        fr = -1;
        if (flush) begin
            m_reset();
            return;
        end
        for (int i = D - 1; i >= 0; i--) if (!m_v[i]) fr = i;
        fa = alloc_valid && m_free() > 0;
        for (int i = 0; i < D; i++) if (m_v[i]) begin
            w = m_snoop(m_s1[i][T-1:0]);
            if (m_b1[i] && w[X]) begin m_s1[i] = w[X-1:0]; m_b1[i] = 0; end
            w = m_snoop(m_s2[i][T-1:0]);
            if (m_b2[i] && w[X]) begin m_s2[i] = w[X-1:0]; m_b2[i] = 0; end
        end
        if (issue_ready && pk >= 0) m_v[pk] = 0;
        if (fa) begin
            m_v[fr] = 1; m_tag[fr] = alloc_tag; m_op[fr] = alloc_op;
            m_s1[fr] = alloc_src1; m_b1[fr] = alloc_busy1;
            m_s2[fr] = alloc_src2; m_b2[fr] = alloc_busy2;
            w = m_snoop(alloc_src1[T-1:0]);
            if (alloc_busy1 && w[X]) begin m_s1[fr] = w[X-1:0]; m_b1[fr] = 0; end
            w = m_snoop(alloc_src2[T-1:0]);
            if (alloc_busy2 && w[X]) begin m_s2[fr] = w[X-1:0]; m_b2[fr] = 0; end
            m_seq[fr] = m_next++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_busy1 = 0; alloc_busy2 = 0;
        alloc_tag = 0; alloc_op = 0; alloc_src1 = 0; alloc_src2 = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; issue_ready = 0;
    endtask

    task automatic set_alloc(input logic [T-1:0] t, input bit b1, input logic [X-1:0] s1,
                             input bit b2, input logic [X-1:0] s2);
        alloc_valid = 1; alloc_tag = t; alloc_op = t + 4'd1;
        alloc_busy1 = b1; alloc_src1 = s1; alloc_busy2 = b2; alloc_src2 = s2;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        checks++;
        if (num_free !== 4'd8 || alloc_ready !== 1'b1 || issue_valid !== 1'b0 || issue_tag !== 4'd0 || issue_src1 !== 32'd0) begin
            errors++;
            $display("FAIL reset: num_free=%0d alloc_ready=%b issue_valid=%b issue_tag=%0d src1=%h expected 8 1 0 0 0",
                     num_free, alloc_ready, issue_valid, issue_tag, issue_src1);
        end
    endtask

    task automatic test_in_order();
        logic [T-1:0] exp_tags [3] = '{4'd3, 4'd5, 4'd7};
        issue_ready = 1;
        for (int k = 0; k < 3; k++) begin
            set_alloc(exp_tags[k], 0, 32'(exp_tags[k]) * 16, 0, 32'h100);
            tick();
            checks++;
            if (issue_valid !== 1'b1 || issue_tag !== exp_tags[k] || issue_src1 !== 32'(exp_tags[k]) * 16 || issue_op !== exp_tags[k] + 4'd1) begin
                errors++;
                $display("FAIL in_order[%0d]: valid=%b tag=%0d src1=%h op=%0d expected tag %0d", k, issue_valid, issue_tag, issue_src1, issue_op, exp_tags[k]);
            end
        end
        alloc_valid = 0;
        tick();
        checks++;
        if (num_free !== 4'd8 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL in_order_drain: num_free=%0d issue_valid=%b expected 8 0", num_free, issue_valid);
        end
        idle();
    endtask

    task automatic test_wakeup();
        set_alloc(4'd2, 1, 32'd9, 0, 32'd1);
        tick();
        set_alloc(4'd4, 0, 32'd4, 0, 32'd4);
        tick();
        alloc_valid = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (issue_valid !== 1'b1 || issue_tag !== 4'd4) begin
                errors++;
                $display("FAIL wakeup_ready_first[%0d]: valid=%b tag=%0d expected 1 4", k, issue_valid, issue_tag);
            end
            if (k == 0) tick();
        end
        cdb_valid = 2'b01; cdb_tag[0] = 4'd9; cdb_data[0] = 32'hDEAD; issue_ready = 1;
        tick();
        cdb_valid = 0;
        checks++;
        if (issue_valid !== 1'b1 || issue_tag !== 4'd2 || issue_src1 !== 32'hDEAD || issue_src2 !== 32'd1) begin
            errors++;
            $display("FAIL wakeup_capture: valid=%b tag=%0d src1=%h src2=%h expected 1 2 dead 1", issue_valid, issue_tag, issue_src1, issue_src2);
        end
        tick();
        idle();
    endtask

    task automatic test_bypass();
        set_alloc(4'd8, 0, 32'h55, 1, 32'd6);
        cdb_valid = 2'b10; cdb_tag[1] = 4'd6; cdb_data[1] = 32'h1234;
        tick();
        idle();
        checks++;
        if (issue_valid !== 1'b1 || issue_tag !== 4'd8 || issue_src2 !== 32'h1234 || issue_src1 !== 32'h55) begin
            errors++;
            $display("FAIL bypass: valid=%b tag=%0d src1=%h src2=%h expected 1 8 55 1234", issue_valid, issue_tag, issue_src1, issue_src2);
        end
        issue_ready = 1;
        tick();
        idle();
    endtask

    task automatic test_full();
        for (int k = 0; k < D; k++) begin
            set_alloc(4'(k), 0, 32'(k), 0, 32'(k));
            tick();
        end
        checks++;
        if (num_free !== 4'd0 || alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: num_free=%0d alloc_ready=%b expected 0 0", num_free, alloc_ready);
        end
        set_alloc(4'd15, 0, 32'd15, 0, 32'd15);
        tick();
        alloc_valid = 0;
        checks++;
        if (num_free !== 4'd0 || issue_tag !== 4'd0) begin
            errors++;
            $display("FAIL full_ignore: num_free=%0d issue_tag=%0d expected 0 0", num_free, issue_tag);
        end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        checks++;
        if (alloc_ready !== 1'b1 || num_free !== 4'd1 || issue_tag !== 4'd1) begin
            errors++;
            $display("FAIL full_release: alloc_ready=%b num_free=%0d issue_tag=%0d expected 1 1 1", alloc_ready, num_free, issue_tag);
        end
        issue_ready = 1;
        for (int k = 1; k < D; k++) begin
            checks++;
            if (issue_valid !== 1'b1 || issue_tag !== 4'(k)) begin
                errors++;
                $display("FAIL full_drain[%0d]: valid=%b tag=%0d expected 1 %0d", k, issue_valid, issue_tag, k);
            end
            tick();
        end
        checks++;
        if (num_free !== 4'd8 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: num_free=%0d issue_valid=%b expected 8 0", num_free, issue_valid);
        end
        idle();
    endtask

    task automatic test_multi_cdb();
        set_alloc(4'd1, 1, 32'd5, 0, 32'd3);
        tick();
        alloc_valid = 0;
        cdb_valid = 2'b11; cdb_tag[0] = 4'd5; cdb_tag[1] = 4'd5; cdb_data[0] = 32'h11; cdb_data[1] = 32'h22;
        tick();
        cdb_valid = 0;
        checks++;
        if (issue_valid !== 1'b1 || issue_src1 !== 32'h11) begin
            errors++;
            $display("FAIL multi_cdb: valid=%b src1=%h expected 1 11", issue_valid, issue_src1);
        end
        issue_ready = 1;
        tick();
        idle();
    endtask

    task automatic test_flush_rst();
        for (int k = 1; k <= 5; k++) begin
            set_alloc(4'(k), 0, 32'd0, 0, 32'd0);
            tick();
        end
        checks++;
        if (num_free !== 4'd3) begin
            errors++;
            $display("FAIL flush_pre: num_free=%0d expected 3", num_free);
        end
        flush = 1;
        set_alloc(4'd9, 0, 32'd0, 0, 32'd0);
        checks++;
        if (issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle_valid: issue_valid=%b expected 1", issue_valid);
        end
        tick();
        idle();
        checks++;
        if (num_free !== 4'd8 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: num_free=%0d issue_valid=%b expected 8 0", num_free, issue_valid);
        end
        for (int k = 0; k < 2; k++) begin
            set_alloc(4'(k + 10), 0, 32'd7, 0, 32'd7);
            tick();
        end
        idle();
        #2 rst = 1;
        #1;
        checks++;
        if (issue_valid !== 1'b0 || num_free !== 4'd8 || alloc_ready !== 1'b1 || issue_tag !== 4'd0 || issue_src1 !== 32'd0) begin
            errors++;
            $display("FAIL async_rst: valid=%b num_free=%0d alloc_ready=%b tag=%0d src1=%h expected 0 8 1 0 0",
                     issue_valid, num_free, alloc_ready, issue_tag, issue_src1);
        end
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int pk;
        idle();
        rst = 1;
        #2 rst = 0;
        m_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 800; c++) begin
            alloc_valid = $urandom_range(0, 9) < 6;
            alloc_tag = T'($urandom);
            alloc_op = O'($urandom);
            alloc_busy1 = $urandom_range(0, 2) == 0;
            alloc_busy2 = $urandom_range(0, 2) == 0;
            alloc_src1 = $urandom;
            alloc_src2 = $urandom;
            cdb_valid = N'($urandom);
            for (int p = 0; p < N; p++) begin
                cdb_tag[p] = T'($urandom);
                cdb_data[p] = $urandom;
            end
            issue_ready = $urandom_range(0, 1) == 1;
            flush = $urandom_range(0, 50) == 0;
            pk = m_pick();
            checks++;
            if (pk < 0 ? (issue_valid !== 1'b0 || issue_tag !== 4'd0 || issue_op !== 4'd0 || issue_src1 !== 32'd0 || issue_src2 !== 32'd0)
                       : (issue_valid !== 1'b1 || issue_tag !== m_tag[pk] || issue_op !== m_op[pk] || issue_src1 !== m_s1[pk] || issue_src2 !== m_s2[pk])) begin
                errors++;
                $display("FAIL random_issue[%0d]: valid=%b tag=%0d op=%0d src1=%h src2=%h expected slot %0d tag=%0d src1=%h src2=%h",
                         c, issue_valid, issue_tag, issue_op, issue_src1, issue_src2, pk,
                         pk < 0 ? 4'd0 : m_tag[pk], pk < 0 ? 32'd0 : m_s1[pk], pk < 0 ? 32'd0 : m_s2[pk]);
            end
            checks++;
            if (num_free !== 4'(m_free()) || alloc_ready !== (m_free() > 0)) begin
                errors++;
                $display("FAIL random_free[%0d]: num_free=%0d alloc_ready=%b expected %0d", c, num_free, alloc_ready, m_free());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_wakeup();
        test_bypass();
        test_full();
        test_multi_cdb();
        test_flush_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
